// File: rtl/armleocpu_writeback_queue.sv
// Writeback queue between execute and the register file: a small circular FIFO
// that drains one write per cycle and forwards the youngest pending value to decode.
module armleocpu_writeback_queue #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd_addr,
    input  logic [31:0]              in_rd_wdata,
    input  logic                     wb_stall,
    output logic [4:0]               rd_addr,
    output logic [31:0]              rd_wdata,
    output logic                     rd_write,
    input  logic [4:0]               rs1_addr,
    output logic                     rs1_fwd_hit,
    output logic [31:0]              rs1_fwd_data,
    input  logic [4:0]               rs2_addr,
    output logic                     rs2_fwd_hit,
    output logic [31:0]              rs2_fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign in_ready = !full;

    // x0 writes are handshaken but never stored
    assign push     = in_valid && in_ready && (in_rd_addr != 5'd0);
    assign pop      = !empty && !wb_stall;

    assign rd_write = pop;
    assign rd_addr  = addr_mem[rd_ptr[AW-1:0]];
    assign rd_wdata = data_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr[AW-1:0]] <= in_rd_addr;
            data_mem[wr_ptr[AW-1:0]] <= in_rd_wdata;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins
    function automatic logic [32:0] lookup(input logic [4:0] addr);
        logic [32:0]   res;
        logic [AW-1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[AW-1:0] + AW'(i);
            if (((AW+1)'(i) < count) && (addr != 5'd0) && (addr_mem[idx] == addr))
                res = {1'b1, data_mem[idx]};
        end
        return res;
    endfunction

    always_comb begin
        {rs1_fwd_hit, rs1_fwd_data} = lookup(rs1_addr);
        {rs2_fwd_hit, rs2_fwd_data} = lookup(rs2_addr);
    end

endmodule

// File: tb/tb_armleocpu_writeback_queue.sv
// Directed self-checking bench for armleocpu_writeback_queue (DEPTH = 2).
module tb_armleocpu_writeback_queue;

    localparam int DEPTH = 2;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             in_rd_addr;
    logic [31:0]            in_rd_wdata;
    logic                   wb_stall;
    logic [4:0]             rd_addr;
    logic [31:0]            rd_wdata;
    logic                   rd_write;
    logic [4:0]             rs1_addr;
    logic                   rs1_fwd_hit;
    logic [31:0]            rs1_fwd_data;
    logic [4:0]             rs2_addr;
    logic                   rs2_fwd_hit;
    logic [31:0]            rs2_fwd_data;
    logic [$clog2(DEPTH):0] count;

    int checks   = 0;
    int failures = 0;

    armleocpu_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd_addr  (in_rd_addr),
        .in_rd_wdata (in_rd_wdata),
        .wb_stall    (wb_stall),
        .rd_addr     (rd_addr),
        .rd_wdata    (rd_wdata),
        .rd_write    (rd_write),
        .rs1_addr    (rs1_addr),
        .rs1_fwd_hit (rs1_fwd_hit),
        .rs1_fwd_data(rs1_fwd_data),
        .rs2_addr    (rs2_addr),
        .rs2_fwd_hit (rs2_fwd_hit),
        .rs2_fwd_data(rs2_fwd_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        in_valid    = 1'b1;
        in_rd_addr  = a;
        in_rd_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_rd_addr = '0; in_rd_wdata = '0;
        wb_stall = 1'b0; rs1_addr = '0; rs2_addr = '0;
        #2;
        check("rst_count",    32'(count),    0);
        check("rst_rd_write", 32'(rd_write), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // in_valid during reset must be ignored
        push(5'd7, 32'h77777777);
        rs1_addr = 5'd7;
        step();
        step();
        check("rst_ignore_count", 32'(count),       0);
        check("rst_fwd_hit",      32'(rs1_fwd_hit), 0);
        check("rst_fwd_data",     rs1_fwd_data,     0);
        in_valid = 1'b0;
        rst = 1'b0;
        step();

        // single write drains the next cycle
        push(5'd5, 32'h11111111);
        rs1_addr = 5'd5;
        #1;
        check("c031_in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        #1;
        check("c031_rd_write", 32'(rd_write), 1);
        check("c031_rd_addr",  32'(rd_addr),  5);
        check("c031_rd_wdata", rd_wdata,      32'h11111111);
        check("c031_count",    32'(count),    1);
        check("c031_fwd_hit",  32'(rs1_fwd_hit), 1);
        check("c031_fwd_data", rs1_fwd_data,  32'h11111111);
        step();
        check("c031_count_after",    32'(count),       0);
        check("c031_rd_write_after", 32'(rd_write),    0);
        check("c031_fwd_hit_after",  32'(rs1_fwd_hit), 0);

        // same register twice under stall: youngest forwards, FIFO order on release
        wb_stall = 1'b1;
        push(5'd3, 32'hA);
        step();
        push(5'd3, 32'hB);
        step();
        in_valid = 1'b0;
        rs1_addr = 5'd3;
        rs2_addr = 5'd3;
        #1;
        check("c032_count",     32'(count),       2);
        check("c032_in_ready",  32'(in_ready),    0);
        check("c032_rd_write",  32'(rd_write),    0);
        check("c032_rs1_hit",   32'(rs1_fwd_hit), 1);
        check("c032_rs1_data",  rs1_fwd_data,     32'hB);
        check("c032_rs2_data",  rs2_fwd_data,     32'hB);
        push(5'd9, 32'h99);
        step();
        in_valid = 1'b0;
        check("c032_full_hold", 32'(count), 2);
        wb_stall = 1'b0;
        #1;
        check("c032_wr0_en",   32'(rd_write), 1);
        check("c032_wr0_addr", 32'(rd_addr),  3);
        check("c032_wr0_data", rd_wdata,      32'hA);
        step();
        check("c032_wr1_en",   32'(rd_write), 1);
        check("c032_wr1_data", rd_wdata,      32'hB);
        check("c032_wr1_count", 32'(count),   1);
        step();
        check("c032_drained",  32'(count),    0);
        check("c032_idle_wr",  32'(rd_write), 0);

        // x0 writes are accepted and dropped
        push(5'd0, 32'hDEADBEEF);
        rs2_addr = 5'd0;
        #1;
        check("c033_in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("c033_count",    32'(count),       0);
        check("c033_rd_write", 32'(rd_write),    0);
        check("c033_rs2_hit",  32'(rs2_fwd_hit), 0);
        check("c033_rs2_data", rs2_fwd_data,     0);

        // continuous streaming across pointer wrap
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push(5'(i + 1), 32'h100 + 32'(i));
            step();
            check($sformatf("c034_count_%0d", i), 32'(count),    1);
            check($sformatf("c034_en_%0d", i),    32'(rd_write), 1);
            check($sformatf("c034_addr_%0d", i),  32'(rd_addr),  32'(i + 1));
            check($sformatf("c034_data_%0d", i),  rd_wdata,      32'h100 + 32'(i));
        end
        in_valid = 1'b0;
        step();
        check("c034_drained", 32'(count), 0);

        // two different registers under stall, then asynchronous reset mid-cycle
        wb_stall = 1'b1;
        push(5'd4, 32'h44);
        step();
        push(5'd6, 32'h66);
        step();
        in_valid = 1'b0;
        rs1_addr = 5'd4;
        rs2_addr = 5'd6;
        #1;
        check("c035_full",     32'(count),       2);
        check("c035_rs1_data", rs1_fwd_data,     32'h44);
        check("c035_rs2_data", rs2_fwd_data,     32'h66);
        #1;
        rst = 1'b1;
        #1;
        check("c035_rst_count", 32'(count),       0);
        check("c035_rst_wr",    32'(rd_write),    0);
        check("c035_rst_hit1",  32'(rs1_fwd_hit), 0);
        check("c035_rst_hit2",  32'(rs2_fwd_hit), 0);
        check("c035_rst_data1", rs1_fwd_data,     0);
        check("c035_rst_ready", 32'(in_ready),    1);
        step();
        rst = 1'b0;
        wb_stall = 1'b0;
        step();
        check("c035_post_wr0",  32'(rd_write), 0);
        step();
        check("c035_post_wr1",  32'(rd_write), 0);
        check("c035_post_cnt",  32'(count),    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/armleocpu_writeback_queue.md
ARMLEOCPU_WRITEBACK_QUEUE -- requirements
Module: armleocpu_writeback_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 2, number of queue entries (power of two, 2..8).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  execute stage presents a register write.
REQ-005 SHALL have port: in_ready  output  1  queue accepts the presented write.
REQ-006 SHALL have port: in_rd_addr  input  5  destination register.
REQ-007 SHALL have port: in_rd_wdata  input  32  destination data.
REQ-008 SHALL have port: wb_stall  input  1  regfile write port unavailable this cycle.
REQ-009 SHALL have port: rd_addr  output  5  regfile write address (head entry).
REQ-010 SHALL have port: rd_wdata  output  32  regfile write data (head entry).
REQ-011 SHALL have port: rd_write  output  1  regfile write enable.
REQ-012 SHALL have port: rs1_addr  input  5  decode read address 1.
REQ-013 SHALL have port: rs1_fwd_hit  output  1  pending write exists for rs1_addr.
REQ-014 SHALL have port: rs1_fwd_data  output  32  youngest pending data for rs1_addr.
REQ-015 SHALL have ports rs2_addr / rs2_fwd_hit / rs2_fwd_data, identical to rs1 set.
REQ-016 SHALL have port: count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 SHALL store entries in a circular buffer with read/write pointers carrying one extra wrap bit; full = pointers equal except wrap bit; empty = pointers equal.
REQ-018 SHALL drive in_ready = (count < DEPTH); in_ready SHALL NOT depend combinationally on wb_stall or a same-cycle pop.
REQ-019 SHALL accept a write on posedge when in_valid && in_ready; accepted entry visible at outputs from the following cycle (latency 1).
REQ-020 SHALL accept but not store writes with in_rd_addr == 0 (pointers and count unchanged).
REQ-021 SHALL drive rd_write = (count != 0) && !wb_stall, with rd_addr/rd_wdata = head entry; outputs combinational from head registers.
REQ-022 SHALL pop the head on posedge when rd_write = 1; exactly one regfile write per cycle maximum.
REQ-023 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers; wrap from entry DEPTH-1 to 0 SHALL be seamless.
REQ-024 SHALL drive rs1_fwd_hit = 1 when rs1_addr != 0 and any valid entry (including the head being written this cycle) has matching rd_addr; rs1_fwd_data SHALL be the data of the youngest matching entry; otherwise rs1_fwd_hit = 0, rs1_fwd_data = 0.
REQ-025 SHALL NOT forward from in_* (no input-to-forward combinational path).
REQ-026 SHALL preserve FIFO order of regfile writes; entries are never dropped except per REQ-020 and reset.
REQ-027 SHALL hold all entries unchanged while wb_stall = 1 and no push occurs.

Reset
REQ-028 SHALL, while rst = 1, clear pointers and count to 0 regardless of clk; rd_write = 0, in_ready = 1, rs1/rs2_fwd_hit = 0, fwd_data = 0.
REQ-029 SHALL discard all pending entries on reset asserted mid-operation; entry data storage need not be cleared.
REQ-030 SHALL ignore in_valid during reset and resume acceptance on first posedge after rst deasserts.

Verification
REQ-031 Push x5=0x11111111, wb_stall=0 -> next cycle rd_write=1, rd_addr=5, rd_wdata=0x11111111, count=1; following cycle count=0, rd_write=0.
REQ-032 wb_stall=1, push x3=0xA, x3=0xB -> count=2, in_ready=0; rs1_addr=3 -> rs1_fwd_hit=1, rs1_fwd_data=0xB; release stall -> writes 0xA then 0xB on consecutive cycles.
REQ-033 Push x0=0xDEADBEEF -> in_ready=1 during accept, count stays 0, rd_write never asserted; rs2_addr=0 -> rs2_fwd_hit=0.
REQ-034 Continuous push every cycle, wb_stall=0, 3*DEPTH entries -> count toggles ≤1, all writes emerge in order across pointer wrap.
REQ-035 Fill to DEPTH under stall, assert rst for one cycle mid-stream -> count=0, rd_write=0, fwd hits 0 immediately (asynchronously), no stale writes after deassert.
